// File: rtl/pin_pkg.sv
// rtl/pin_pkg.sv - shared types and constants for the PIN digit sender
package pin_pkg;

  localparam int PIN_W      = 8;
  localparam int DIGIT_W    = 2;
  localparam int PIN_DIGITS = 4;
  localparam int IDX_W      = $clog2(PIN_DIGITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT_RESP,
    ST_DRAIN
  } state_e;

  // Digit idx of a PIN word, most significant pair first.
  function automatic logic [DIGIT_W-1:0] pin_digit(input logic [PIN_W-1:0] p,
                                                   input logic [IDX_W-1:0] idx);
    logic [PIN_W-1:0] s;
    s = p << (DIGIT_W * idx);
    return s[PIN_W-1 -: DIGIT_W];
  endfunction

endpackage

// File: rtl/pin_gap_timer.sv
// rtl/pin_gap_timer.sv - loadable saturating down-counter with terminal-count flag
module pin_gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over counting; the count parks at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pin_sender.sv
// rtl/pin_sender.sv - serialises a PIN word to the checker; lockout under PIN_SENDER_LOCKOUT_EN
module pin_sender
  import pin_pkg::*;
#(
  parameter int DIGIT_GAP    = 4,
  parameter int RESP_TIMEOUT = 64,
  parameter int MAX_FAILS    = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [PIN_W-1:0]   pin,
  output logic [DIGIT_W-1:0] digit,
  output logic               submit,
  input  logic               correct_in,
  input  logic               incorrect_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic               locked
);

  localparam int GAP_W = $clog2(DIGIT_GAP + 1);
  localparam int TO_W  = $clog2(RESP_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [PIN_W-1:0]   pin_q, pin_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               to_q, to_d;
  logic               gap_load, gap_en, gap_tc;
  logic               to_load, to_en, to_tc;
  logic               attempt_pass, attempt_fail;
  logic               start_block;

  // Gap timer: loaded to DIGIT_GAP-1 in SEND so GAP lasts exactly DIGIT_GAP cycles.
  pin_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (gap_load),
    .load_val_i (GAP_W'(DIGIT_GAP - 1)),
    .en_i       (gap_en),
    .tc_o       (gap_tc)
  );

  // Response timer: expires once RESP_TIMEOUT cycles have elapsed in WAIT_RESP.
  pin_gap_timer #(.W(TO_W)) u_resp_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (to_load),
    .load_val_i (TO_W'(RESP_TIMEOUT)),
    .en_i       (to_en),
    .tc_o       (to_tc)
  );

  // Next-state and strobe logic; incorrect has priority over correct.
  always_comb begin
    state_d      = state_q;
    pin_d        = pin_q;
    idx_d        = idx_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    to_d         = to_q;
    gap_load     = 1'b0;
    gap_en       = 1'b0;
    to_load      = 1'b0;
    to_en        = 1'b0;
    submit       = 1'b0;
    done         = 1'b0;
    attempt_pass = 1'b0;
    attempt_fail = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !start_block) begin
          pin_d   = pin;
          idx_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          to_d    = 1'b0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        submit   = 1'b1;
        gap_load = 1'b1;
        state_d  = ST_GAP;
      end
      ST_GAP: begin
        gap_en = 1'b1;
        if (gap_tc) begin
          if (idx_q == IDX_W'(PIN_DIGITS - 1)) begin
            to_load = 1'b1;
            state_d = ST_WAIT_RESP;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SEND;
          end
        end
      end
      ST_WAIT_RESP: begin
        to_en = 1'b1;
        if (incorrect_in) begin
          fail_d       = 1'b1;
          done         = 1'b1;
          attempt_fail = 1'b1;
          state_d      = ST_DRAIN;
        end else if (correct_in) begin
          pass_d       = 1'b1;
          done         = 1'b1;
          attempt_pass = 1'b1;
          state_d      = ST_DRAIN;
        end else if (to_tc) begin
          to_d         = 1'b1;
          done         = 1'b1;
          attempt_fail = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!correct_in && !incorrect_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and attempt registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pin_q   <= '0;
      idx_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pin_q   <= pin_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
    end
  end

  assign digit   = (state_q == ST_IDLE) ? '0 : pin_digit(pin_q, idx_q);
  assign busy    = (state_q != ST_IDLE);
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign timeout = to_q;

`ifdef PIN_SENDER_LOCKOUT_EN
  localparam int FC_W = $clog2(MAX_FAILS + 1);

  logic [FC_W-1:0] fails_q, fails_d;
  logic            locked_q, locked_d;

  // Consecutive-fail count; a timeout counts as a failure, a pass clears it.
  always_comb begin
    fails_d  = fails_q;
    locked_d = locked_q;
    if (attempt_pass) begin
      fails_d = '0;
    end else if (attempt_fail && (fails_q != FC_W'(MAX_FAILS))) begin
      fails_d = fails_q + 1'b1;
    end
    if (fails_d == FC_W'(MAX_FAILS)) begin
      locked_d = 1'b1;
    end
  end

  // Lockout registers; locked only clears through reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fails_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      fails_q  <= fails_d;
      locked_q <= locked_d;
    end
  end

  assign locked      = locked_q;
  assign start_block = locked_q;
`else
  // MAX_FAILS has no role without lockout.
  logic unused_lockout;
  assign unused_lockout = (MAX_FAILS > 0) ^ attempt_pass ^ attempt_fail;
  assign locked         = 1'b0;
  assign start_block    = 1'b0;
`endif

endmodule
